// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle for countdown_timer_ctrl.
// Signalling contract: start and stop are single-cycle pulses and hold is a
// level, all sampled on the rising clock edge; there is no ready back-pressure.
// done is the only response strobe: one registered cycle per expiry, and
// count/busy are valid every cycle.
interface countdown_timer_ctrl_if;
  logic       start;
  logic [9:0] load_val;
  logic       stop;
  logic       hold;
  logic [9:0] count;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output start, load_val, stop, hold,
    input  count, busy, done, state_dbg
  );

  modport slave (
    input  start, load_val, stop, hold,
    output count, busy, done, state_dbg
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer built around one ten_bit_decrementer.
// Loads a 10-bit period, decrements once per PRESCALE clocks, and pulses done
// for one cycle on expiry. stop aborts (no done), hold freezes.
// Optional build macro AUTO_RELOAD_EN: on expiry, reload the period and keep
// running instead of returning to IDLE.
module countdown_timer_ctrl #(
  parameter int PRESCALE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  countdown_timer_ctrl_if.slave bus
);

  localparam logic [7:0] PCNT_MAX = 8'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] count_r;
  logic [9:0] dec_s;
  logic       dec_o;
  logic [7:0] pcnt;
  logic       done_r;
  logic       tick;
  logic       expire;
`ifdef AUTO_RELOAD_EN
  logic [9:0] period_r;
`endif

  ten_bit_decrementer u_dec (
    .a (count_r),
    .s (dec_s),
    .o (dec_o)
  );

  // A borrow means count is already 0; never decrement through it.
  assign tick   = (pcnt == PCNT_MAX) && !dec_o;
  assign expire = tick && (count_r == 10'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: stop beats hold beats tick; leaving HOLD resumes counting at once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start && (bus.load_val != 10'd0)) state_nxt = RUN;
      end
      RUN, HOLD: begin
        if (bus.stop)      state_nxt = IDLE;
        else if (bus.hold) state_nxt = HOLD;
        else if (expire) begin
`ifdef AUTO_RELOAD_EN
          state_nxt = RUN;
`else
          state_nxt = IDLE;
`endif
        end
        else               state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: count, prescaler, done pulse (and reload period when enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 10'd0;
      pcnt     <= 8'd0;
      done_r   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      period_r <= 10'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.load_val != 10'd0) begin
              count_r  <= bus.load_val;
              pcnt     <= 8'd0;
`ifdef AUTO_RELOAD_EN
              period_r <= bus.load_val;
`endif
            end else begin
              count_r <= 10'd0;
              done_r  <= 1'b1;
            end
          end
        end
        RUN, HOLD: begin
          if (bus.stop) begin
            pcnt <= 8'd0;
          end else if (!bus.hold) begin
            if (tick) begin
              pcnt <= 8'd0;
              if (expire) begin
                done_r <= 1'b1;
`ifdef AUTO_RELOAD_EN
                count_r <= period_r;
`else
                count_r <= 10'd0;
`endif
              end else begin
                count_r <= dec_s;
              end
            end else begin
              pcnt <= pcnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: busy decoded from state; count/done come straight from registers.
  always_comb begin
    bus.busy      = (state == RUN) || (state == HOLD);
    bus.count     = count_r;
    bus.done      = done_r;
    bus.state_dbg = state;
  end

endmodule

// Ten-bit decrement: s = a - 1, o = borrow out (set only when a == 0).
module ten_bit_decrementer (
  input  logic [9:0] a,
  output logic [9:0] s,
  output logic       o
);
  assign {o, s} = {1'b0, a} - 11'd1;
endmodule
